// File: rtl/io_uart_tx_block.sv
// UART transmitter (8N1) with a TX FIFO, driven by single-cycle bridge strobes.
// Access decode is registered, so every register effect lands one edge after the strobe.
module io_uart_tx_block #(
    parameter int          BLOCK_INDEX     = 0,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [31:0]                 WrData,
    input  logic                        WrEn,
    input  logic                        RdEn,
    input  logic [7:0]                  BlockSelect,
    input  logic [3:0]                  RegAddress,
    output logic                        Tx,
    output logic                        TxBusy,
    output logic [$clog2(FIFO_DEPTH):0] FifoCount,
    output logic                        FifoEmpty,
    output logic                        FifoFull,
    output logic                        Overflow,
    output logic                        Enable
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic             wr_r, rd_r;
    logic [3:0]       addr_r;
    logic [15:0]      data_r;
    logic             push_s, div_wr_s, ctrl_wr_s, rd_clr_s, flush_s, ovf_clr_s;
    logic             accept_s, ovf_set_s, pop_s, full_s, empty_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic             enable_r, ovf_r, empty_r, full_r;
    logic [15:0]      divisor_r, eff_div_s, bit_div_r, timer_r;
    state_t           state_r, state_nxt_s;
    logic             start_s, bit_end_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [7:0]       shift_r;
    logic             tx_r, tx_nxt_s, busy_r, busy_nxt_s;
    logic             unused_s;

    assign unused_s = &{1'b0, WrData[31:16]};

    // Capture the qualified bridge strobe, address and data
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_r   <= 1'b0;
            rd_r   <= 1'b0;
            addr_r <= 4'd0;
            data_r <= 16'd0;
        end else begin
            wr_r   <= WrEn & BlockSelect[BLOCK_INDEX];
            rd_r   <= RdEn & BlockSelect[BLOCK_INDEX];
            addr_r <= RegAddress;
            data_r <= WrData[15:0];
        end
    end

    // Register decode of the captured access
    always_comb begin
        push_s    = 1'b0;
        div_wr_s  = 1'b0;
        ctrl_wr_s = 1'b0;
        rd_clr_s  = 1'b0;
        if (wr_r) begin
            case (addr_r)
                4'd0:    push_s    = 1'b1;
                4'd1:    div_wr_s  = 1'b1;
                4'd2:    ctrl_wr_s = 1'b1;
                default: push_s    = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
        if (rd_r && (addr_r == 4'd3)) begin
            rd_clr_s = 1'b1;
        end else begin
            rd_clr_s = 1'b0;
        end
    end

    assign flush_s   = ctrl_wr_s & data_r[2];
    assign ovf_clr_s = (ctrl_wr_s & data_r[1]) | rd_clr_s;
    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == '0);
    assign eff_div_s = (divisor_r < 16'd2) ? 16'd2 : divisor_r;
    assign pop_s     = start_s;

    // FIFO accept/overflow/count; a flush empties first, then a concurrent push lands
    always_comb begin
        accept_s    = 1'b0;
        ovf_set_s   = 1'b0;
        count_nxt_s = count_r;
        if (flush_s) begin
            accept_s    = push_s;
            count_nxt_s = push_s ? CNT_W'(1) : '0;
        end else begin
            if (push_s && (!full_s || pop_s)) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
            ovf_set_s = push_s & full_s & ~pop_s;
            case ({accept_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // FIFO storage (no reset needed: reads are gated by count)
    always_ff @(posedge Clock) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= data_r[7:0];
        end
    end

    // FIFO pointers, count and status flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (flush_s) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == '0);
            full_r  <= (count_nxt_s == DEPTH_C);
        end
    end

    // Control, divisor and sticky overflow (set beats clear)
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            enable_r  <= 1'b0;
            divisor_r <= DEFAULT_DIVISOR;
            ovf_r     <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= data_r[0];
            end
            if (div_wr_s) begin
                divisor_r <= data_r;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; the last STOP cycle may launch the next frame directly
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        bit_end_s   = (timer_r == 16'd0);
        case (state_r)
            ST_IDLE: begin
                if (enable_r && !empty_s) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (idx_r == 3'd7)) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (enable_r && !empty_s) begin
                        state_nxt_s = ST_START;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next line level, bit index and busy, all registered below
    always_comb begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        if (state_r == ST_DATA) begin
            idx_nxt_s = bit_end_s ? (idx_r + 3'd1) : idx_r;
        end else begin
            idx_nxt_s = 3'd0;
        end
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_r[idx_nxt_s];
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Frame datapath: head byte, latched bit period and the bit timer
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shift_r   <= 8'd0;
            bit_div_r <= DEFAULT_DIVISOR;
            timer_r   <= 16'd0;
            idx_r     <= 3'd0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            if (start_s) begin
                shift_r   <= mem_r[rd_ptr_r];
                bit_div_r <= eff_div_s;
                timer_r   <= eff_div_s - 16'd1;
            end else if (state_r != ST_IDLE) begin
                timer_r <= bit_end_s ? (bit_div_r - 16'd1) : (timer_r - 16'd1);
            end
            idx_r  <= idx_nxt_s;
            tx_r   <= tx_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    assign Tx        = tx_r;
    assign TxBusy    = busy_r;
    assign FifoCount = count_r;
    assign FifoEmpty = empty_r;
    assign FifoFull  = full_r;
    assign Overflow  = ovf_r;
    assign Enable    = enable_r;

endmodule

// File: tb/tb_io_uart_tx_block.sv
// Directed bench for io_uart_tx_block: queued bytes are scoreboarded and
// compared against frames decoded cycle by cycle from the Tx line.
module tb_io_uart_tx_block;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] WrData = 32'd0;
    logic        WrEn = 1'b0;
    logic        RdEn = 1'b0;
    logic [7:0]  BlockSelect = 8'd0;
    logic [3:0]  RegAddress = 4'd0;
    logic        Tx, TxBusy, FifoEmpty, FifoFull, Overflow, Enable;
    logic [3:0]  FifoCount;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  sb[$];

    io_uart_tx_block #(
        .BLOCK_INDEX(0),
        .FIFO_DEPTH(8),
        .DEFAULT_DIVISOR(16'd434)
    ) dut (
        .Clock(Clock), .Reset(Reset), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
        .BlockSelect(BlockSelect), .RegAddress(RegAddress), .Tx(Tx), .TxBusy(TxBusy),
        .FifoCount(FifoCount), .FifoEmpty(FifoEmpty), .FifoFull(FifoFull),
        .Overflow(Overflow), .Enable(Enable)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [7:0] sel);
        WrEn = 1'b1; RegAddress = a; WrData = d; BlockSelect = sel;
        tick();
        WrEn = 1'b0; RegAddress = 4'd0; WrData = 32'd0; BlockSelect = 8'd0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] sel);
        RdEn = 1'b1; RegAddress = a; BlockSelect = sel;
        tick();
        RdEn = 1'b0; RegAddress = 4'd0; BlockSelect = 8'd0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        sb.push_back(b);
        wr(4'd0, {24'd0, b}, 8'h01);
    endtask

    // Waits for a start bit, then checks every clock of the 10-bit frame
    task automatic rx_frame(input int div, output int gap);
        logic [9:0] pat;
        logic [7:0] expb;
        gap = 0;
        while (Tx !== 1'b0 && gap < 1000) begin
            tick();
            gap++;
        end
        if (Tx !== 1'b0) begin
            vectors++;
            miscompares++;
            $error("FAIL rx_start: observed no start bit expected one within 1000 clocks");
            return;
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL rx_unexpected: observed a frame expected none");
            expb = 8'd0;
        end else begin
            expb = sb.pop_front();
        end
        pat = {1'b1, expb, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < div; c++) begin
                check($sformatf("rx_bit%0d_byte%02h", j, expb), 32'(Tx), 32'(pat[j]));
                check("rx_busy", 32'(TxBusy), 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        int gap;

        // Reset values
        tick(); tick();
        check("rst_tx", 32'(Tx), 32'd1);
        check("rst_busy", 32'(TxBusy), 32'd0);
        check("rst_count", 32'(FifoCount), 32'd0);
        check("rst_empty", 32'(FifoEmpty), 32'd1);
        check("rst_full", 32'(FifoFull), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_enable", 32'(Enable), 32'd0);
        check("rst_divisor", 32'(dut.divisor_r), 32'd434);
        Reset = 1'b1;
        tick();

        // Single frame 0xA5 at divisor 4, Tx falls two edges after the strobe
        wr(4'd1, 32'd4, 8'h01);
        wr(4'd2, 32'd1, 8'h01);
        push_byte(8'hA5);
        tick();
        check("lat_edge1_tx", 32'(Tx), 32'd1);
        rx_frame(4, gap);
        check("lat_gap", 32'(gap), 32'd1);
        check("a5_empty", 32'(FifoEmpty), 32'd1);
        check("a5_idle_busy", 32'(TxBusy), 32'd0);
        check("a5_idle_tx", 32'(Tx), 32'd1);

        // Fill while disabled, overflow on the 9th push, read-to-clear
        wr(4'd2, 32'd0, 8'h01);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) push_byte(8'h10 + 8'(i * 17));
            else       wr(4'd0, 32'h0000_00EE, 8'h01);
        end
        tick();
        check("fill_count", 32'(FifoCount), 32'd8);
        check("fill_full", 32'(FifoFull), 32'd1);
        check("fill_empty", 32'(FifoEmpty), 32'd0);
        check("fill_ovf", 32'(Overflow), 32'd1);
        check("fill_tx_idle", 32'(Tx), 32'd1);
        rd(4'd3, 8'h01);
        tick();
        check("rd3_ovf_clr", 32'(Overflow), 32'd0);
        check("rd3_count", 32'(FifoCount), 32'd8);
        wr(4'd2, 32'd1, 8'h01);
        for (int i = 0; i < 8; i++) begin
            rx_frame(4, gap);
            check($sformatf("b2b_gap%0d", i), 32'(gap), (i == 0) ? 32'd2 : 32'd0);
        end
        check("b2b_empty", 32'(FifoEmpty), 32'd1);
        check("b2b_busy", 32'(TxBusy), 32'd0);

        // Divisor 1 acts as 2; a divisor write at frame launch waits for the next frame
        wr(4'd1, 32'd1, 8'h01);
        push_byte(8'h3C);
        wr(4'd1, 32'd6, 8'h01);
        push_byte(8'hC3);
        rx_frame(2, gap);
        check("div2_gap", 32'(gap), 32'd0);
        rx_frame(6, gap);
        check("div6_gap", 32'(gap), 32'd0);

        // Deselected strobes and out-of-range addresses change nothing
        wr(4'd0, 32'h0000_0011, 8'h02);
        wr(4'd1, 32'h0000_0009, 8'hFE);
        wr(4'd2, 32'h0000_0004, 8'h02);
        for (int a = 4; a < 16; a++) wr(4'(a), 32'h0000_0003, 8'h01);
        tick(); tick();
        check("nop_count", 32'(FifoCount), 32'd0);
        check("nop_empty", 32'(FifoEmpty), 32'd1);
        check("nop_enable", 32'(Enable), 32'd1);
        check("nop_divisor", 32'(dut.divisor_r), 32'd6);
        check("nop_busy", 32'(TxBusy), 32'd0);
        check("nop_tx", 32'(Tx), 32'd1);

        // Flush mid-frame: current frame completes, queued bytes discarded
        wr(4'd1, 32'd4, 8'h01);
        wr(4'd2, 32'd0, 8'h01);
        push_byte(8'h81);
        wr(4'd0, 32'h0000_0042, 8'h01);
        wr(4'd0, 32'h0000_0024, 8'h01);
        wr(4'd0, 32'h0000_0018, 8'h01);
        tick();
        check("flush_pre_count", 32'(FifoCount), 32'd4);
        wr(4'd2, 32'd1, 8'h01);
        tick();
        wr(4'd2, 32'd5, 8'h01);
        rx_frame(4, gap);
        check("flush_gap", 32'(gap), 32'd0);
        check("flush_count", 32'(FifoCount), 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("flush_tx_high", 32'(Tx), 32'd1);
            tick();
        end
        check("flush_busy", 32'(TxBusy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset during DATA takes effect without a clock edge
        wr(4'd0, 32'h0000_00F0, 8'h01);
        wr(4'd0, 32'h0000_0055, 8'h01);
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy", 32'(TxBusy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("arst_tx", 32'(Tx), 32'd1);
        check("arst_busy", 32'(TxBusy), 32'd0);
        check("arst_count", 32'(FifoCount), 32'd0);
        check("arst_empty", 32'(FifoEmpty), 32'd1);
        check("arst_enable", 32'(Enable), 32'd0);
        check("arst_divisor", 32'(dut.divisor_r), 32'd434);
        tick();
        Reset = 1'b1;
        tick(); tick();
        check("post_rst_tx", 32'(Tx), 32'd1);
        check("post_rst_busy", 32'(TxBusy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
